sequenciador_movimentos: RTL and testbench
==========================================

# sequenciador_movimentos

Move sequencer in front of the servo manager. Buffers a solution string of 3-bit move codes in an internal FIFO. On command, issues the moves one at a time to the servo manager with an `iniciar`/`move` handshake, waits for `pronto`, and inserts a settle gap between moves. A watchdog flags an error if a move never completes. It sits between the solver/serial front end and `gerenciador_servos`.

## Interface
Parameters:
- `DEPTH`, 32: FIFO capacity in moves; power of two, ≥2.
- `MOVE_W`, 3: move code width; matches the servo manager `move` input.
- `GAP_CYCLES`, 50_000: idle cycles between `pronto` and the next `iniciar` (1 ms at 50 MHz); 0 is legal.
- `TIMEOUT_CYCLES`, 150_000_000: maximum wait for `pronto` per move; ≥2.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears the FIFO, counters and state.
- `escreve` in 1: push `move_entrada` into the FIFO this cycle.
- `move_entrada` in MOVE_W: move code to push.
- `iniciar_execucao` in 1: start draining the FIFO; level sampled in OCIOSO only.
- `abortar` in 1: synchronous abort from any state.
- `pronto_servos` in 1: `pronto` from the servo manager.
- `iniciar_servos` out 1: one-cycle pulse to the servo manager `iniciar`.
- `move_servos` out MOVE_W: registered move code to the servo manager `move`.
- `cheio` out 1: FIFO full.
- `vazio` out 1: FIFO empty.
- `movimentos_restantes` out $clog2(DEPTH+1): FIFO occupancy.
- `ocupado` out 1: high in EMITE, AGUARDA and INTERVALO.
- `concluido` out 1: one-cycle pulse when the sequence ends normally.
- `erro` out 1: high while in ERRO.
- `db_estado` out 3: state code, for debug.

## Operation
- States and encodings: OCIOSO=0, EMITE=1, AGUARDA=2, INTERVALO=3, FIM=4, ERRO=5.
- OCIOSO:
  - If `iniciar_execucao` is high and the FIFO is not empty, go to EMITE.
  - If `iniciar_execucao` is high and the FIFO is empty, go to FIM.
- EMITE (one cycle):
  - `iniciar_servos`=1.
  - `move_servos` is loaded with the FIFO head (it becomes valid in this cycle) and the FIFO pops.
  - Next state is AGUARDA, with the watchdog counter cleared.
- AGUARDA:
  - Completion is the rising edge of `pronto_servos` (current value 1, registered previous value 0). A level that was already high on entry does not count.
  - On completion: go to INTERVALO if GAP_CYCLES>0; otherwise go to EMITE if the FIFO is not empty, or FIM if it is empty.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without completion, go to ERRO.
- INTERVALO: count GAP_CYCLES cycles, then go to EMITE (FIFO not empty) or FIM (FIFO empty).
- FIM: `concluido`=1 for one cycle, then go to OCIOSO.
- ERRO:
  - Holds `erro`=1 and freezes the FIFO contents.
  - Leaves only on `abortar` or `reset`; `iniciar_execucao` is ignored.
- `abortar` has priority over every transition. From any state it goes to OCIOSO next cycle and flushes the FIFO. A push in the same cycle is dropped.
- FIFO rules:
  - A push when full is dropped and has no other effect.
  - Pushing is allowed in every state except ERRO, so moves can be appended during execution.
  - A simultaneous push and pop keeps the occupancy unchanged.
- `move_servos` holds its last value outside EMITE.

## Timing
- Reset values: state=OCIOSO; all outputs 0 except `vazio`=1; FIFO pointers 0; watchdog and gap counters 0; previous-`pronto` register 0.
- Start latency: `iniciar_execucao` sampled at edge N gives `iniciar_servos` high during cycle N+1.
- Issue period per move: 1 (EMITE) + wait for the `pronto` edge + GAP_CYCLES.
- A `pronto` rising edge on cycle P gives the next `iniciar_servos` at P+1+GAP_CYCLES.
- `movimentos_restantes`, `cheio` and `vazio` are registered and update the cycle after a push or pop.
- A `reset` during execution stops the sequence immediately; a move already started in the servo manager is not tracked further.

## Structure
- Package `sequenciador_pkg`: state encodings, move code width, default GAP/TIMEOUT constants.
- Sub-module `fila_movimentos`: synchronous FIFO with parameters DEPTH and MOVE_W.
  - Ports: push, pop, flush, data in/out, full, empty, count.
  - Head data is visible without a read latency (first-word fall-through).
- Controller FSM, watchdog counter, gap counter and `pronto` edge register are in the top module.

## Test plan
- Push 3,1,5, then `iniciar_execucao` → `move_servos` is 3,1,5 in order, each with a single `iniciar_servos` pulse. Using a servo model that pulses `pronto` 20 cycles after `iniciar` and GAP_CYCLES=4, consecutive `iniciar` pulses are 25 cycles apart. After the last `pronto` and its gap: `concluido` pulses once and `vazio`=1.
- With DEPTH=4, push 6 moves → `cheio`=1 after 4 pushes, `movimentos_restantes`=4, and the last two moves are never issued.
- `iniciar_execucao` with an empty FIFO → `concluido` pulses in cycle N+2 and `iniciar_servos` never rises.
- Servo model never raises `pronto`, TIMEOUT_CYCLES=100 → `erro`=1 100 cycles after EMITE. `iniciar_execucao` is ignored; `abortar` returns to OCIOSO with `vazio`=1.
- `pronto_servos` held high before start → no false completion; the move completes only on a later 0→1 edge.
- `abortar` in INTERVALO with 2 moves queued, plus a simultaneous push → OCIOSO next cycle, `movimentos_restantes`=0, no further `iniciar_servos`.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// Shared types and defaults for the move sequencer.
// State codes are also exported on db_estado.
package sequenciador_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    EMITE     = 3'd1,
    AGUARDA   = 3'd2,
    INTERVALO = 3'd3,
    FIM       = 3'd4,
    ERRO      = 3'd5
  } estado_t;

  localparam int unsigned MOVE_W_PADRAO  = 3;
  localparam int unsigned GAP_PADRAO     = 50_000;
  localparam int unsigned TIMEOUT_PADRAO = 150_000_000;

endpackage

// File: rtl/fila_movimentos.sv
// First-word fall-through FIFO holding queued move codes.
// Full pushes and empty pops are ignored; flush empties it.
module fila_movimentos #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned MOVE_W = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [MOVE_W-1:0]          dado_i,
  output logic [MOVE_W-1:0]          dado_o,
  output logic                       cheio_o,
  output logic                       vazio_o,
  output logic [$clog2(DEPTH+1)-1:0] contagem_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [MOVE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_ok;
  logic              rd_ok;

  assign cheio_o    = (cnt_q == CW'(DEPTH));
  assign vazio_o    = (cnt_q == '0);
  assign contagem_o = cnt_q;
  assign dado_o     = mem_q[rd_q];
  assign wr_ok      = push_i & ~cheio_o;
  assign rd_ok      = pop_i & ~vazio_o;

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + PW'(1);
      if (rd_ok) rd_q <= rd_q + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_q] <= dado_i;
  end

endmodule

// File: rtl/sequenciador_movimentos.sv
// Drains queued moves into the servo manager one at a time,
// with a settle gap between moves and a per-move watchdog.
module sequenciador_movimentos
  import sequenciador_pkg::*;
#(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned MOVE_W         = MOVE_W_PADRAO,
  parameter int unsigned GAP_CYCLES     = GAP_PADRAO,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_PADRAO
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       escreve,
  input  logic [MOVE_W-1:0]          move_entrada,
  input  logic                       iniciar_execucao,
  input  logic                       abortar,
  input  logic                       pronto_servos,
  output logic                       iniciar_servos,
  output logic [MOVE_W-1:0]          move_servos,
  output logic                       cheio,
  output logic                       vazio,
  output logic [$clog2(DEPTH+1)-1:0] movimentos_restantes,
  output logic                       ocupado,
  output logic                       concluido,
  output logic                       erro,
  output logic [2:0]                 db_estado
);

  estado_t           estado_q, estado_d;
  estado_t           proximo;
  logic [MOVE_W-1:0] move_q, move_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       gap_q, gap_d;
  logic              pronto_ant_q;
  logic              concluido_q, concluido_d;
  logic              borda;
  logic              push;
  logic              pop;
  logic [MOVE_W-1:0] cabeca;

  assign borda   = pronto_servos & ~pronto_ant_q;
  assign push    = escreve & (estado_q != ERRO) & ~abortar;
  assign pop     = (estado_q == EMITE) & ~abortar;
  assign proximo = vazio ? FIM : EMITE;

  fila_movimentos #(
    .DEPTH  (DEPTH),
    .MOVE_W (MOVE_W)
  ) u_fila (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (abortar),
    .dado_i     (move_entrada),
    .dado_o     (cabeca),
    .cheio_o    (cheio),
    .vazio_o    (vazio),
    .contagem_o (movimentos_restantes)
  );

  always_comb begin
    estado_d    = estado_q;
    move_d      = move_q;
    wd_d        = '0;
    gap_d       = '0;
    concluido_d = 1'b0;
    unique case (estado_q)
      OCIOSO: if (iniciar_execucao) estado_d = proximo;
      EMITE: estado_d = AGUARDA;
      AGUARDA: begin
        wd_d = wd_q + 32'd1;
        if (borda)
          estado_d = (GAP_CYCLES > 0) ? INTERVALO : proximo;
        else if (wd_q == TIMEOUT_CYCLES - 2)
          estado_d = ERRO;
      end
      INTERVALO: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == GAP_CYCLES - 1) estado_d = proximo;
      end
      FIM: begin
        estado_d    = OCIOSO;
        concluido_d = 1'b1;
      end
      ERRO: estado_d = ERRO;
      default: estado_d = OCIOSO;
    endcase
    if (abortar) begin
      estado_d    = OCIOSO;
      concluido_d = 1'b0;
    end
    // Load on entry so the code is already valid during EMITE.
    if (estado_d == EMITE) move_d = cabeca;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      move_q       <= '0;
      wd_q         <= '0;
      gap_q        <= '0;
      pronto_ant_q <= 1'b0;
      concluido_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      move_q       <= move_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      pronto_ant_q <= pronto_servos;
      concluido_q  <= concluido_d;
    end
  end

  assign iniciar_servos = (estado_q == EMITE);
  assign move_servos    = move_q;
  assign concluido      = concluido_q;
  assign erro           = (estado_q == ERRO);
  assign db_estado      = estado_q;
  assign ocupado        = (estado_q == EMITE) |
                          (estado_q == AGUARDA) |
                          (estado_q == INTERVALO);

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Bench for the move sequencer: queue-based model checked every
// cycle, plus directed scenarios with hand-computed timings.
module tb_sequenciador_movimentos;

  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 100;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          escreve = 1'b0;
  logic [2:0]    move_entrada = '0;
  logic          iniciar_execucao = 1'b0;
  logic          abortar = 1'b0;
  logic          pronto_servos;
  logic          pronto_man = 1'b0;
  logic          pronto_auto = 1'b0;
  int            servo_mode = 0;

  logic          iniciar_servos;
  logic [2:0]    move_servos;
  logic          cheio;
  logic          vazio;
  logic [CW-1:0] movimentos_restantes;
  logic          ocupado;
  logic          concluido;
  logic          erro;
  logic [2:0]    db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  assign pronto_servos = (servo_mode == 2) ? pronto_man : pronto_auto;

  sequenciador_movimentos #(
    .DEPTH          (DEPTH),
    .MOVE_W         (3),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .escreve              (escreve),
    .move_entrada         (move_entrada),
    .iniciar_execucao     (iniciar_execucao),
    .abortar              (abortar),
    .pronto_servos        (pronto_servos),
    .iniciar_servos       (iniciar_servos),
    .move_servos          (move_servos),
    .cheio                (cheio),
    .vazio                (vazio),
    .movimentos_restantes (movimentos_restantes),
    .ocupado              (ocupado),
    .concluido            (concluido),
    .erro                 (erro),
    .db_estado            (db_estado)
  );

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: queue of pending moves, countdown timers, spec state codes.
  int q[$];
  int st = 0, mv = 0, wl = 0, gl = 0, n0 = 0, nst = 0;
  bit conc = 0, pprev = 0, edg = 0, mdl_ok = 0;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      st = 0; mv = 0; wl = 0; gl = 0;
      conc = 0; mdl_ok = 1;
    end else begin
      n0   = q.size();
      edg  = pronto_servos && !pprev;
      conc = (st == 4) && !abortar;
      nst  = st;
      if (abortar) nst = 0;
      else case (st)
        0: if (iniciar_execucao) nst = (n0 > 0) ? 1 : 4;
        1: begin nst = 2; wl = TMO - 1; end
        2: if (edg) nst = (GAP > 0) ? 3 : ((n0 > 0) ? 1 : 4);
           else begin wl--; if (wl == 0) nst = 5; end
        3: begin gl--; if (gl == 0) nst = (n0 > 0) ? 1 : 4; end
        4: nst = 0;
        default: nst = st;
      endcase
      if (nst == 3 && st != 3) gl = GAP;
      if (abortar) q.delete();
      else begin
        if (st == 1) void'(q.pop_front());
        if (escreve && st != 5 && n0 < DEPTH)
          q.push_back(int'(move_entrada));
      end
      if (nst == 1) mv = q[0];
      st = nst;
    end
    pprev = pronto_servos;
  end

  always @(negedge clock) begin
    if (mdl_ok) begin
      check("estado", db_estado, st);
      check("iniciar_servos", iniciar_servos, st == 1);
      check("move_servos", move_servos, mv);
      check("restantes", movimentos_restantes, q.size());
      check("vazio", vazio, q.size() == 0);
      check("cheio", cheio, q.size() == DEPTH);
      check("ocupado", ocupado, st >= 1 && st <= 3);
      check("concluido", concluido, conc);
      check("erro", erro, st == 5);
    end
  end

  // Event logs and a servo that answers 20 cycles after iniciar.
  int ini_cyc[$], ini_mv[$], conc_cyc[$], err_cyc[$], pend[$];
  logic erro_ant = 1'b0;

  always @(negedge clock) begin
    if (iniciar_servos === 1'b1) begin
      ini_cyc.push_back(cyc);
      ini_mv.push_back(int'(move_servos));
      if (servo_mode == 0) pend.push_back(cyc + 20);
    end
    if (concluido === 1'b1) conc_cyc.push_back(cyc);
    if (erro === 1'b1 && !erro_ant) err_cyc.push_back(cyc);
    erro_ant = (erro === 1'b1);
    pronto_auto = (pend.size() > 0 && pend[0] == cyc);
    if (pronto_auto) void'(pend.pop_front());
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic push(input int m);
    escreve = 1'b1;
    move_entrada = m[2:0];
    tick();
    escreve = 1'b0;
  endtask

  task automatic start(output int c0);
    iniciar_execucao = 1'b1;
    c0 = cyc;
    tick();
    iniciar_execucao = 1'b0;
  endtask

  task automatic wait_conc(input int base, input int lim, input string nm);
    for (int i = 0; i < lim && conc_cyc.size() <= base; i++) tick();
    check(nm, conc_cyc.size(), base + 1);
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    for (int i = 0; i < lim && db_estado != s[2:0]; i++) tick();
    check(nm, db_estado, s);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, bi, bc, be;
    int exp1[3];
    int exp2[4];
    exp1 = '{3, 1, 5};
    exp2 = '{7, 6, 5, 4};

    tick(3);
    reset = 1'b0;
    tick();
    check("rst_vazio", vazio, 1);
    check("rst_restantes", movimentos_restantes, 0);
    check("rst_estado", db_estado, 0);
    check("rst_iniciar", iniciar_servos, 0);

    // Three moves with a 20-cycle servo and GAP=4.
    servo_mode = 0;
    push(3); push(1); push(5);
    check("t1_restantes", movimentos_restantes, 3);
    bi = ini_cyc.size(); bc = conc_cyc.size();
    start(c0);
    wait_conc(bc, 300, "t1_concluido");
    check("t1_n_iniciar", ini_cyc.size() - bi, 3);
    if (ini_cyc.size() - bi == 3 && conc_cyc.size() > bc) begin
      for (int i = 0; i < 3; i++) check("t1_move", ini_mv[bi+i], exp1[i]);
      check("t1_latencia", ini_cyc[bi], c0 + 1);
      check("t1_periodo1", ini_cyc[bi+1] - ini_cyc[bi], 25);
      check("t1_periodo2", ini_cyc[bi+2] - ini_cyc[bi+1], 25);
      check("t1_fim", conc_cyc[bc], ini_cyc[bi+2] + 26);
    end
    tick(3);
    check("t1_vazio", vazio, 1);
    check("t1_um_concluido", conc_cyc.size() - bc, 1);

    // Overfill a 4-deep queue.
    push(7); push(6); push(5); push(4);
    check("t2_cheio", cheio, 1);
    check("t2_restantes", movimentos_restantes, 4);
    push(2); push(1);
    check("t2_restantes_apos", movimentos_restantes, 4);
    bi = ini_cyc.size(); bc = conc_cyc.size();
    start(c0);
    wait_conc(bc, 400, "t2_concluido");
    check("t2_n_iniciar", ini_cyc.size() - bi, 4);
    if (ini_cyc.size() - bi == 4)
      for (int i = 0; i < 4; i++) check("t2_move", ini_mv[bi+i], exp2[i]);

    // Start with nothing queued.
    tick(2);
    bi = ini_cyc.size(); bc = conc_cyc.size();
    start(c0);
    tick(3);
    check("t3_n_concluido", conc_cyc.size() - bc, 1);
    if (conc_cyc.size() > bc) check("t3_fim", conc_cyc[bc], c0 + 2);
    check("t3_sem_iniciar", ini_cyc.size() - bi, 0);

    // Servo never answers: watchdog.
    servo_mode = 1;
    push(2); push(6);
    be = err_cyc.size();
    start(c0);
    wait_state(5, 300, "t4_erro_estado");
    check("t4_n_erro", err_cyc.size() - be, 1);
    if (err_cyc.size() > be) check("t4_erro_ciclo", err_cyc[be], c0 + 101);
    check("t4_congelado", movimentos_restantes, 1);
    push(3);
    iniciar_execucao = 1'b1;
    tick();
    iniciar_execucao = 1'b0;
    tick(4);
    check("t4_ainda_erro", erro, 1);
    check("t4_restantes", movimentos_restantes, 1);
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    check("t4_ocioso", db_estado, 0);
    check("t4_vazio", vazio, 1);

    // pronto already high at start must not count.
    servo_mode = 2;
    pronto_man = 1'b1;
    tick(3);
    push(4);
    bi = ini_cyc.size(); bc = conc_cyc.size();
    start(c0);
    tick(30);
    check("t5_aguarda", db_estado, 2);
    pronto_man = 1'b0;
    tick();
    pronto_man = 1'b1;
    tick();
    pronto_man = 1'b0;
    wait_conc(bc, 50, "t5_concluido");
    check("t5_n_iniciar", ini_cyc.size() - bi, 1);

    // Abort during the gap with two moves left and a push.
    servo_mode = 0;
    push(1); push(2); push(3);
    start(c0);
    wait_state(3, 100, "t6_intervalo");
    check("t6_restantes_antes", movimentos_restantes, 2);
    abortar = 1'b1;
    escreve = 1'b1;
    move_entrada = 3'd7;
    tick();
    abortar = 1'b0;
    escreve = 1'b0;
    check("t6_ocioso", db_estado, 0);
    check("t6_restantes", movimentos_restantes, 0);
    bi = ini_cyc.size();
    tick(60);
    check("t6_sem_iniciar", ini_cyc.size() - bi, 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
